// File: rtl/bram_arb_pkg.sv
// Shared definitions for the BRAM port arbiter: FSM encoding and BRAM timing.
package bram_arb_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } arb_state_e;

  // Cycles from BRAM_EN to valid BRAM_RDDATA.
  localparam int unsigned BRAM_RD_LAT = 1;

endpackage

// File: rtl/bram_arb_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, with wrap.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  int unsigned pos;

  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = k + ptr;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!any && req[pos]) begin
        any = 1'b1;
        idx = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/bram_arb.sv
// Round-robin arbiter sharing one BRAM port among NUM_REQ requesters, with
// locked bursts capped at MAX_BURST beats and owner-tagged read returns.
module bram_arb
  import bram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*4-1:0]      req_we,
  input  logic [NUM_REQ*32-1:0]     req_wrdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [31:0]               rddata,
  output logic [ADDR_W-1:0]         BRAM_ADDR,
  output logic [31:0]               BRAM_WRDATA,
  output logic [3:0]                BRAM_WE,
  output logic                      BRAM_EN,
  input  logic [31:0]               BRAM_RDDATA
);

  localparam int unsigned      IDX_W    = $clog2(NUM_REQ);
  localparam int unsigned      CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  logic              owner_req;
  logic              owner_lock;
  logic [ADDR_W-1:0] own_addr;
  logic [3:0]        own_we;
  logic [31:0]       own_wrdata;
  logic              beat;
  logic              release_own;

  logic [BRAM_RD_LAT-1:0] rd_pipe_v;
  logic [IDX_W-1:0]       rd_pipe_tag [BRAM_RD_LAT];
  logic                   rd_issue;
  logic                   rd_out_v;
  logic [IDX_W-1:0]       rd_out_tag;
  logic [31:0]            rd_hold_q;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req(req),
    .ptr(rr_ptr_q),
    .idx(pick_idx),
    .any(pick_any)
  );

  always_comb begin
    owner_req  = 1'b0;
    owner_lock = 1'b0;
    own_addr   = '0;
    own_we     = '0;
    own_wrdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_req  = req[i];
        owner_lock = req_lock[i];
        own_addr   = req_addr[i*ADDR_W +: ADDR_W];
        own_we     = req_we[i*4 +: 4];
        own_wrdata = req_wrdata[i*32 +: 32];
      end
    end
  end

  // Reset overrides everything, so a beat is never presented while areset is high.
  assign beat     = (state_q == S_OWN) && owner_req && !areset;
  assign rd_issue = beat && (own_we == 4'b0000);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    release_own = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = S_OWN;
        end
      end
      S_OWN: begin
        if (owner_req) begin
          cnt_d = cnt_q + 1'b1;
          if (!owner_lock || (cnt_d == CNT_MAX)) release_own = 1'b1;
        end else begin
          release_own = 1'b1;
        end
        if (release_own) begin
          state_d  = S_IDLE;
          rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt         = '0;
    BRAM_EN     = 1'b0;
    BRAM_ADDR   = '0;
    BRAM_WE     = '0;
    BRAM_WRDATA = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      gnt[i] = beat && (owner_q == IDX_W'(i));
    end
    if (beat) begin
      BRAM_EN     = 1'b1;
      BRAM_ADDR   = own_addr;
      BRAM_WE     = own_we;
      BRAM_WRDATA = own_wrdata;
    end
  end

  // The read tag travels alongside the BRAM latency so a release does not disturb it.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_pipe_v <= '0;
      for (int unsigned k = 0; k < BRAM_RD_LAT; k++) rd_pipe_tag[k] <= '0;
      rd_hold_q <= '0;
    end else begin
      rd_pipe_v[0]   <= rd_issue;
      rd_pipe_tag[0] <= owner_q;
      for (int unsigned k = 1; k < BRAM_RD_LAT; k++) begin
        rd_pipe_v[k]   <= rd_pipe_v[k-1];
        rd_pipe_tag[k] <= rd_pipe_tag[k-1];
      end
      if (rd_out_v) rd_hold_q <= BRAM_RDDATA;
    end
  end

  assign rd_out_v   = rd_pipe_v[BRAM_RD_LAT-1] && !areset;
  assign rd_out_tag = rd_pipe_tag[BRAM_RD_LAT-1];

  always_comb begin
    rvalid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rvalid[i] = rd_out_v && (rd_out_tag == IDX_W'(i));
    end
    if (areset)        rddata = '0;
    else if (rd_out_v) rddata = BRAM_RDDATA;
    else               rddata = rd_hold_q;
  end

endmodule

// File: tb/tb_bram_arb.sv
// Self-checking bench for bram_arb: directed scenarios plus random traffic
// compared every cycle against a behavioural arbitration model.
module tb_bram_arb;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int MB = 16;

  logic            aclk = 1'b0;
  logic            areset;
  logic [N-1:0]    req, req_lock, gnt, rvalid;
  logic [N*AW-1:0] req_addr;
  logic [N*4-1:0]  req_we;
  logic [N*32-1:0] req_wrdata;
  logic [31:0]     rddata, BRAM_WRDATA, BRAM_RDDATA;
  logic [AW-1:0]   BRAM_ADDR;
  logic [3:0]      BRAM_WE;
  logic            BRAM_EN;

  bram_arb #(
    .NUM_REQ(N),
    .ADDR_W(AW),
    .MAX_BURST(MB)
  ) dut (
    .aclk(aclk), .areset(areset), .req(req), .req_lock(req_lock),
    .req_addr(req_addr), .req_we(req_we), .req_wrdata(req_wrdata),
    .gnt(gnt), .rvalid(rvalid), .rddata(rddata),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_WRDATA(BRAM_WRDATA), .BRAM_WE(BRAM_WE),
    .BRAM_EN(BRAM_EN), .BRAM_RDDATA(BRAM_RDDATA)
  );

  always #5 aclk = ~aclk;

  // BRAM behavioural model, one cycle read latency.
  logic [31:0] mem [256];
  always @(posedge aclk) begin
    if (BRAM_EN) begin
      if (BRAM_WE == 4'b0000) BRAM_RDDATA <= mem[BRAM_ADDR[9:2]];
      else
        for (int b = 0; b < 4; b++)
          if (BRAM_WE[b]) mem[BRAM_ADDR[9:2]][b*8 +: 8] <= BRAM_WRDATA[b*8 +: 8];
    end
  end

  int total = 0;
  int bad   = 0;

  // Requester driver state
  int          rem  [N];
  bit          lk   [N];
  int          mode [N];   // 0 random, 1 read, 2 write
  logic [31:0] a_v  [N];
  logic [31:0] d_v  [N];
  logic [3:0]  w_v  [N];

  // Reference model: owner -1 means no tenure in progress
  int          m_owner, m_ptr, m_cnt, p_tag;
  logic [31:0] p_data, last_rd;
  logic [31:0] ref_mem [256];

  // Observed DUT behaviour
  int          g_own[$], g_cyc[$], rv_own[$], rv_cyc[$];
  int          cyc_n = 0;
  logic [31:0] cap_rd;

  function automatic logic [31:0] init_word(int i);
    return 32'h5A00_0000 | (32'(i) << 8) | (32'(i) ^ 32'h33);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  task automatic refresh(input int i);
    a_v[i] = $urandom;
    d_v[i] = $urandom;
    case (mode[i])
      1:       w_v[i] = 4'h0;
      2:       w_v[i] = 4'($urandom_range(1, 15));
      default: w_v[i] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    endcase
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]               = rem[i] > 0;
      req_lock[i]          = lk[i];
      req_addr[i*AW +: AW] = a_v[i];
      req_we[i*4 +: 4]     = w_v[i];
      req_wrdata[i*32 +: 32] = d_v[i];
    end
  endtask

  task automatic model_edge();
    logic [31:0] a, d;
    logic [3:0]  w;
    if (areset) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; p_tag = -1; last_rd = '0;
      return;
    end
    if (p_tag >= 0) last_rd = p_data;
    p_tag = -1;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++)
        if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      m_cnt = 0;
    end else if (req[m_owner]) begin
      a = req_addr[m_owner*AW +: AW];
      w = req_we[m_owner*4 +: 4];
      d = req_wrdata[m_owner*32 +: 32];
      if (w == 4'h0) begin
        p_tag = m_owner; p_data = ref_mem[a[9:2]];
      end else begin
        for (int b = 0; b < 4; b++) if (w[b]) ref_mem[a[9:2]][b*8 +: 8] = d[b*8 +: 8];
      end
      m_cnt++;
      if (!req_lock[m_owner] || m_cnt == MB) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1;
      end
    end else begin
      m_ptr = (m_owner + 1) % N; m_owner = -1;
    end
  endtask

  // One clock: called 1ns after a rising edge, checks mid-cycle, steps the model.
  task automatic cyc();
    logic [N-1:0] e_gnt, e_rv, g_s;
    logic [31:0]  e_rd, e_addr, e_wd;
    logic [3:0]   e_we;
    bit           beat;
    #3;
    beat   = !areset && m_owner >= 0 && req[m_owner];
    e_gnt  = beat ? N'(1 << m_owner) : '0;
    e_addr = beat ? req_addr[m_owner*AW +: AW] : '0;
    e_we   = beat ? req_we[m_owner*4 +: 4] : '0;
    e_wd   = beat ? req_wrdata[m_owner*32 +: 32] : '0;
    e_rv   = (!areset && p_tag >= 0) ? N'(1 << p_tag) : '0;
    e_rd   = areset ? '0 : (p_tag >= 0 ? p_data : last_rd);
    chk("gnt", gnt, e_gnt);
    chk("bram_en", BRAM_EN, beat);
    chk("bram_addr", BRAM_ADDR, e_addr);
    chk("bram_we", BRAM_WE, e_we);
    chk("bram_wrdata", BRAM_WRDATA, e_wd);
    chk("rvalid", rvalid, e_rv);
    chk("rddata", rddata, e_rd);
    g_s = gnt;
    for (int i = 0; i < N; i++) begin
      if (gnt[i])    begin g_own.push_back(i);  g_cyc.push_back(cyc_n);  end
      if (rvalid[i]) begin rv_own.push_back(i); rv_cyc.push_back(cyc_n); cap_rd = rddata; end
    end
    @(posedge aclk);
    model_edge();
    cyc_n++;
    #1;
    for (int i = 0; i < N; i++)
      if (g_s[i] && rem[i] > 0) begin rem[i]--; refresh(i); end
    drive();
  endtask

  function automatic bit busy();
    for (int i = 0; i < N; i++) if (rem[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_until_idle(input int maxc);
    int n = 0;
    while (busy() && n < maxc) begin cyc(); n++; end
    chk("idle_timeout", busy(), 1'b0);
    cyc(); cyc(); cyc();
  endtask

  task automatic do_reset();
    areset = 1'b1;
    for (int i = 0; i < N; i++) begin rem[i] = 0; lk[i] = 0; mode[i] = 0; end
    drive();
    cyc();
    areset = 1'b0;
    drive();
    cyc();
    g_own.delete(); g_cyc.delete(); rv_own.delete(); rv_cyc.delete();
  endtask

  int n1;

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = init_word(i); ref_mem[i] = init_word(i); end
    BRAM_RDDATA = '0;
    areset  = 1'b1;
    m_owner = -1; m_ptr = 0; m_cnt = 0; p_tag = -1; last_rd = '0; p_data = '0;
    for (int i = 0; i < N; i++) begin rem[i] = 0; lk[i] = 0; mode[i] = 0; refresh(i); end
    drive();
    @(posedge aclk); #1;
    do_reset();

    // Single read from requester 2 at 0x40
    mode[2] = 1; refresh(2); a_v[2] = 32'h40; rem[2] = 1; drive();
    run_until_idle(10);
    chk("sr_owner", g_own.size() == 1 ? g_own[0] : -1, 2);
    chk("sr_rv_tag", rv_own.size() == 1 ? rv_own[0] : -1, 2);
    chk("sr_rv_lat", rv_cyc.size() == 1 ? rv_cyc[0] - g_cyc[0] : -1, 1);
    chk("sr_rddata", cap_rd, init_word(16));

    // Four single-beat requesters from pointer 0
    do_reset();
    for (int i = 0; i < N; i++) rem[i] = 1;
    drive();
    run_until_idle(40);
    chk("rr_count", g_own.size(), 4);
    for (int i = 0; i < 4 && i < g_own.size(); i++) chk("rr_order", g_own[i], i);
    for (int i = 1; i < 4 && i < g_cyc.size(); i++) chk("rr_gap", g_cyc[i] - g_cyc[i-1], 2);

    // Locked 20-beat write burst capped at MAX_BURST, requester 3 waiting
    do_reset();
    mode[1] = 2; refresh(1); lk[1] = 1; rem[1] = 20;
    mode[3] = 2; refresh(3); rem[3] = 1;
    drive();
    run_until_idle(120);
    chk("burst_count", g_own.size(), 21);
    n1 = 0;
    for (int i = 0; i < 16 && i < g_own.size(); i++) if (g_own[i] == 1) n1++;
    chk("burst_first16", n1, 16);
    chk("burst_then3", g_own.size() > 16 ? g_own[16] : -1, 3);
    n1 = 0;
    for (int i = 17; i < g_own.size(); i++) if (g_own[i] == 1) n1++;
    chk("burst_resume", n1, 4);

    // Locked read burst; last read returns during the next arbitration
    do_reset();
    mode[1] = 1; refresh(1); lk[1] = 1; rem[1] = MB;
    mode[2] = 2; refresh(2); rem[2] = 1;
    drive();
    run_until_idle(80);
    chk("lastrd_count", rv_own.size(), MB);
    chk("lastrd_tag", rv_own.size() == MB ? rv_own[MB-1] : -1, 1);
    chk("lastrd_when", rv_own.size() == MB ? rv_cyc[MB-1] - g_cyc[MB-1] : -1, 1);
    chk("lastrd_next", g_own.size() > MB ? g_own[MB] : -1, 2);
    chk("lastrd_gap", g_cyc.size() > MB ? g_cyc[MB] - g_cyc[MB-1] : -1, 2);

    // Reset in the middle of a locked burst by requester 0
    do_reset();
    mode[0] = 1; refresh(0); lk[0] = 1; rem[0] = 10; drive();
    for (int i = 0; i < 4; i++) cyc();
    areset = 1'b1; rem[0] = 0; drive();
    cyc();
    areset = 1'b0; g_own.delete(); g_cyc.delete();
    rem[1] = 1; drive();
    run_until_idle(10);
    chk("rst_next_owner", g_own.size() == 1 ? g_own[0] : -1, 1);

    // Owner drops req mid-tenure; pointer moves to owner+1
    do_reset();
    lk[2] = 1; rem[2] = 3; drive();
    n1 = 0;
    while (g_own.size() == 0 && n1 < 10) begin cyc(); n1++; end
    rem[2] = 0; rem[0] = 1; rem[3] = 1; drive();
    run_until_idle(20);
    chk("drop_count", g_own.size(), 3);
    chk("drop_next", g_own.size() > 1 ? g_own[1] : -1, 3);
    chk("drop_after", g_own.size() > 2 ? g_own[2] : -1, 0);

    // Random traffic
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) begin
          rem[i] = $urandom_range(1, 20); lk[i] = $urandom_range(0, 1); mode[i] = 0; refresh(i);
        end else if (rem[i] > 0 && $urandom_range(0, 199) == 0) rem[i] = 0;
      end
      areset = ($urandom_range(0, 149) == 0);
      drive();
      cyc();
    end
    areset = 1'b0;
    for (int i = 0; i < N; i++) lk[i] = 0;
    drive();
    run_until_idle(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_arb.md
BRAM_ARB -- requirements
Module: bram_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter ADDR_W, default 32: BRAM byte-address width.
REQ-003 SHALL have parameter MAX_BURST, default 16: max beats per locked tenure, 1..256.
REQ-004 aclk  input  1  sole clock; all logic on rising edge.
REQ-005 areset  input  1  reset, synchronous, active-high.
REQ-006 req  input  NUM_REQ  per-requester access request, held until granted beat.
REQ-007 req_lock  input  NUM_REQ  per-requester burst hold; keep grant across consecutive beats.
REQ-008 req_addr  input  NUM_REQ*ADDR_W  packed per-requester byte address.
REQ-009 req_we  input  NUM_REQ*4  packed per-requester byte write enables; 0 = read.
REQ-010 req_wrdata  input  NUM_REQ*32  packed per-requester write data.
REQ-011 gnt  output  NUM_REQ  one-hot beat accept; beat issued to BRAM in a cycle where gnt[i]&&req[i].
REQ-012 rvalid  output  NUM_REQ  one-hot read-return strobe.
REQ-013 rddata  output  32  read return data, valid with rvalid.
REQ-014 BRAM_ADDR  output  ADDR_W  BRAM address.
REQ-015 BRAM_WRDATA  output  32  BRAM write data.
REQ-016 BRAM_WE  output  4  BRAM byte write enable.
REQ-017 BRAM_EN  output  1  BRAM enable.
REQ-018 BRAM_RDDATA  input  32  BRAM read data, 1-cycle latency after BRAM_EN.

Function
REQ-019 FSM states S_IDLE, S_OWN; owner register (index), rr pointer, beat counter.
REQ-020 S_IDLE: if any req, select winner = first set req scanning from rr pointer upward with wrap; register owner, go S_OWN; no gnt this cycle.
REQ-021 S_OWN: gnt[owner] = req[owner]; all other gnt bits 0.
REQ-022 Beat = cycle in S_OWN with req[owner]; BRAM_EN=1, BRAM_ADDR/WE/WRDATA = owner's slice, combinational pass-through.
REQ-023 Non-beat cycles: BRAM_EN=0, BRAM_WE=0, BRAM_ADDR=0, BRAM_WRDATA=0.
REQ-024 Beat counter clears on S_IDLE->S_OWN, increments per beat.
REQ-025 Release after a beat when req_lock[owner]==0, or beat count reaches MAX_BURST; also release in S_OWN with req[owner]==0.
REQ-026 On release: rr pointer <= owner+1 mod NUM_REQ, state <= S_IDLE; a new winner is gnt'd no earlier than 2 cycles after release beat (1 idle-arbitration cycle).
REQ-027 Read beat (BRAM_WE==0) in cycle N: rvalid[owner@N]=1 and rddata=BRAM_RDDATA in cycle N+1, registered owner tag, independent of later release.
REQ-028 Write beats produce no rvalid.
REQ-029 rddata SHALL hold last read value when rvalid==0.
REQ-030 Simultaneous requests: round-robin guarantees each continuously requesting master a tenure within NUM_REQ tenures.
REQ-031 MAX_BURST=1: every tenure is exactly one beat regardless of req_lock.
REQ-032 Counter width clog2(MAX_BURST+1); no wrap.

Reset
REQ-033 areset high at a clock edge: state <= S_IDLE, rr pointer <= 0, owner <= 0, counter <= 0.
REQ-034 During/after reset cycle: gnt=0, rvalid=0, rddata=0, BRAM_EN=0, BRAM_WE=0, BRAM_ADDR=0, BRAM_WRDATA=0.
REQ-035 Reset mid-tenure SHALL drop pending rvalid; no BRAM access in the reset cycle.

Structure
REQ-036 Shared package holds state encodings (S_IDLE, S_OWN) and BRAM_RD_LAT=1 constant.
REQ-037 One sub-module rr_pick: combinational round-robin selector (req, pointer -> index, any).
REQ-038 Per-requester slice mux is inline in bram_arb.

Verification
REQ-039 Single read: req[2]=1, addr 0x40, we=0 -> gnt[2] 1 cycle later, BRAM_ADDR=0x40 EN=1, rvalid[2]=1 next cycle with rddata=BRAM mem[0x40].
REQ-040 All four req single-beat, lock=0, pointer 0 -> grant order 0,1,2,3, each gnt 2 cycles apart.
REQ-041 req[1] locked burst of 20 writes, MAX_BURST=16, req[3] waiting -> 16 beats to 1, release, req[3] granted, then req[1] resumes.
REQ-042 Read beat on last locked beat then release -> rvalid tagged to old owner even while next arbitration runs.
REQ-043 areset asserted mid-burst of owner 0 -> next cycle all outputs 0, state idle, pointer 0; post-reset req[1] only -> gnt[1].
REQ-044 Owner drops req without lock mid-tenure -> release, no BRAM_EN, pointer advances to owner+1.
